calc_input_parser: RTL and testbench

CALC_INPUT_PARSER -- requirements
Module: calc_input_parser

---
 rtl/calc_pkg.sv | 17 +
 rtl/calc_digit_accum.sv | 15 +
 rtl/calc_input_parser.sv | 116 +++++++++++
 tb/tb_calc_input_parser.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: token codes, ALU opcodes and parser states shared by the calculator blocks
package calc_pkg;
  localparam logic [4:0] TOK_AC  = 5'd16;
  localparam logic [4:0] TOK_ADD = 5'd17;
  localparam logic [4:0] TOK_DIV = 5'd20;
  localparam logic [4:0] TOK_EQ  = 5'd21;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} opcode_t;
  typedef enum logic [2:0] {ENTER_A, OP_WAIT, ENTER_B, ISSUE, WAIT_RES, RESULT, ERROR} state_t;
  function automatic logic is_op(input logic [4:0] tok);
    return tok >= TOK_ADD && tok <= TOK_DIV;
  endfunction
  function automatic opcode_t tok_opcode(input logic [4:0] tok);
    logic [4:0] d;
    d = tok - TOK_ADD;
    return opcode_t'(d[1:0]);
  endfunction
endpackage

// File: rtl/calc_digit_accum.sv
// calc_digit_accum: acc*10+digit with a flag when the result no longer fits in WIDTH bits
module calc_digit_accum #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [3:0]       digit,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);
  localparam int W4 = WIDTH + 4;
  logic [W4-1:0] full;
  assign full = W4'(acc) * W4'(10) + W4'(digit);
  assign sum  = full[WIDTH-1:0];
  assign ovf  = |full[W4-1:WIDTH];
endmodule

// File: rtl/calc_input_parser.sv
// calc_input_parser: turns keypad tokens into ALU requests and tracks the displayed value
module calc_input_parser import calc_pkg::*; #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_op_a,
  output logic [WIDTH-1:0] o_op_b,
  output logic [1:0]       o_opcode,
  output logic             o_alu_valid,
  input  logic             i_alu_ready,
  input  logic [WIDTH-1:0] i_res,
  input  logic             i_res_valid,
  input  logic             i_res_err,
  output logic [WIDTH-1:0] o_display,
  output logic             o_error
);
  state_t state, state_n;
  opcode_t opc, opc_n, pop, pop_n;
  logic [WIDTH-1:0] a, a_n, b, b_n, disp, sum, acc_in, dig;
  logic peq, peq_n, ovf, take, is_dig, is_opt;
  assign o_ready     = state != ISSUE && state != WAIT_RES;
  assign o_alu_valid = state == ISSUE;
  assign o_error     = state == ERROR;
  assign o_op_a      = a;
  assign o_op_b      = b;
  assign o_opcode    = opc;
  assign o_display   = disp;
  assign take        = i_valid && o_ready;
  assign is_dig      = i_data < 5'd10;
  assign is_opt      = is_op(i_data);
  assign dig         = WIDTH'(i_data[3:0]);
  assign acc_in      = state == ENTER_B ? b : a;
  calc_digit_accum #(.WIDTH(WIDTH)) u_accum (.acc(acc_in), .digit(i_data[3:0]), .sum(sum), .ovf(ovf));
  always_comb begin
    state_n = state;
    a_n = a;
    b_n = b;
    opc_n = opc;
    pop_n = pop;
    peq_n = peq;
    case (state)
      ENTER_A: begin
        if (take && is_dig && !ovf) a_n = sum;
        else if (take && is_opt) begin
          opc_n = tok_opcode(i_data);
          state_n = OP_WAIT;
        end
      end
      OP_WAIT: begin
        if (take && is_opt) opc_n = tok_opcode(i_data);
        else if (take && is_dig) begin
          b_n = dig;
          state_n = ENTER_B;
        end
      end
      ENTER_B: begin
        if (take && is_dig && !ovf) b_n = sum;
        else if (take && (is_opt || i_data == TOK_EQ)) begin
          peq_n = i_data == TOK_EQ;
          pop_n = is_opt ? tok_opcode(i_data) : pop;
          state_n = ISSUE;
        end
      end
      ISSUE: state_n = i_alu_ready ? WAIT_RES : ISSUE;
      WAIT_RES: begin
        if (i_res_valid && i_res_err) state_n = ERROR;
        else if (i_res_valid) begin
          a_n = i_res;
          opc_n = peq ? opc : pop;
          state_n = peq ? RESULT : OP_WAIT;
        end
      end
      RESULT: begin
        if (take && is_dig) begin
          a_n = dig;
          state_n = ENTER_A;
        end else if (take && is_opt) begin
          opc_n = tok_opcode(i_data);
          state_n = OP_WAIT;
        end
      end
      default: ;
    endcase
    if (take && i_data == TOK_AC) begin
      a_n = '0;
      b_n = '0;
      opc_n = OP_ADD;
      pop_n = OP_ADD;
      peq_n = 1'b0;
      state_n = ENTER_A;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ENTER_A;
      a <= '0;
      b <= '0;
      opc <= OP_ADD;
      pop <= OP_ADD;
      peq <= 1'b0;
      disp <= '0;
    end else begin
      state <= state_n;
      a <= a_n;
      b <= b_n;
      opc <= opc_n;
      pop <= pop_n;
      peq <= peq_n;
      disp <= state_n == ENTER_B ? b_n : state_n == ERROR ? '0 : a_n;
    end
  end
endmodule

// File: tb/tb_calc_input_parser.sv
// tb_calc_input_parser: directed table plus hand sequences for ALU handshake, error and reset cases
module tb_calc_input_parser;
  import calc_pkg::*;
  localparam int W = 16;
  localparam logic [4:0] AC = 5'd16, ADD = 5'd17, SUB = 5'd18, MUL = 5'd19, DIV = 5'd20, EQ = 5'd21;
  logic clk = 0, rst_n = 0, i_valid = 0, i_alu_ready = 0, i_res_valid = 0, i_res_err = 0;
  logic [4:0] i_data = 0;
  logic [W-1:0] i_res = 0, o_op_a, o_op_b, o_display;
  logic [1:0] o_opcode;
  logic o_ready, o_alu_valid, o_error;
  int tests = 0, fails = 0;
  calc_input_parser #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_op_a(o_op_a), .o_op_b(o_op_b), .o_opcode(o_opcode), .o_alu_valid(o_alu_valid),
    .i_alu_ready(i_alu_ready), .i_res(i_res), .i_res_valid(i_res_valid), .i_res_err(i_res_err),
    .o_display(o_display), .o_error(o_error)
  );
  always #5 clk = ~clk;
  typedef struct {logic [4:0] tok; logic [W-1:0] disp; logic err;} vec_t;
  vec_t vecs[13];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic send(input logic [4:0] t);
    chk("ready_before_token", 32'(o_ready), 1);
    i_data = t;
    i_valid = 1;
    @(posedge clk);
    #1 i_valid = 0;
    @(negedge clk);
  endtask
  task automatic alu(input logic [W-1:0] ea, input logic [W-1:0] eb, input logic [1:0] eo,
                     input logic [W-1:0] r, input logic e, input int dly, input bit give_res);
    int n = 0;
    while (!o_alu_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("alu_valid", 32'(o_alu_valid), 1);
    chk("op_a", 32'(o_op_a), 32'(ea));
    chk("op_b", 32'(o_op_b), 32'(eb));
    chk("opcode", 32'(o_opcode), 32'(eo));
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("ready_low_issue", 32'(o_ready), 0);
      chk("hold_valid", 32'(o_alu_valid), 1);
      chk("hold_op_a", 32'(o_op_a), 32'(ea));
    end
    i_alu_ready = 1;
    @(negedge clk);
    i_alu_ready = 0;
    chk("valid_drop", 32'(o_alu_valid), 0);
    chk("ready_low_wait", 32'(o_ready), 0);
    if (give_res) begin
      i_res = r;
      i_res_err = e;
      i_res_valid = 1;
      @(negedge clk);
      i_res_valid = 0;
      i_res_err = 0;
    end
  endtask
  initial begin
    vecs[0]  = '{5'd6, 16'd6, 1'b0};
    vecs[1]  = '{5'd5, 16'd65, 1'b0};
    vecs[2]  = '{5'd5, 16'd655, 1'b0};
    vecs[3]  = '{5'd3, 16'd6553, 1'b0};
    vecs[4]  = '{5'd5, 16'd65535, 1'b0};
    vecs[5]  = '{5'd6, 16'd65535, 1'b0};
    vecs[6]  = '{5'd12, 16'd65535, 1'b0};
    vecs[7]  = '{5'd25, 16'd65535, 1'b0};
    vecs[8]  = '{EQ, 16'd65535, 1'b0};
    vecs[9]  = '{ADD, 16'd65535, 1'b0};
    vecs[10] = '{5'd7, 16'd7, 1'b0};
    vecs[11] = '{5'd4, 16'd74, 1'b0};
    vecs[12] = '{AC, 16'd0, 1'b0};
    #12;
    chk("rst_ready", 32'(o_ready), 1);
    chk("rst_display", 32'(o_display), 0);
    chk("rst_alu_valid", 32'(o_alu_valid), 0);
    chk("rst_error", 32'(o_error), 0);
    chk("rst_op_a", 32'(o_op_a), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      send(vecs[i].tok);
      chk($sformatf("vec%0d_display", i), 32'(o_display), 32'(vecs[i].disp));
      chk($sformatf("vec%0d_error", i), 32'(o_error), 32'(vecs[i].err));
    end
    send(1); send(2); send(ADD); send(3); send(EQ);
    alu(12, 3, 0, 15, 0, 0, 1);
    chk("add_display", 32'(o_display), 15);
    chk("add_state", 32'(dut.state), 32'(RESULT));
    send(AC); send(5); send(ADD); send(SUB); send(2); send(EQ);
    alu(5, 2, 1, 3, 0, 0, 1);
    chk("sub_display", 32'(o_display), 3);
    send(AC); send(2); send(MUL); send(3); send(ADD);
    alu(2, 3, 2, 6, 0, 3, 1);
    chk("chain_display", 32'(o_display), 6);
    chk("chain_state", 32'(dut.state), 32'(OP_WAIT));
    send(4);
    chk("chain_b_display", 32'(o_display), 4);
    send(EQ);
    alu(6, 4, 0, 10, 0, 0, 1);
    chk("chain_result", 32'(o_display), 10);
    send(AC); send(8); send(DIV); send(0); send(EQ);
    alu(8, 0, 3, 0, 1, 0, 1);
    chk("div0_error", 32'(o_error), 1);
    chk("div0_display", 32'(o_display), 0);
    send(5);
    chk("err_drop_display", 32'(o_display), 0);
    chk("err_drop_error", 32'(o_error), 1);
    send(AC);
    chk("ac_error", 32'(o_error), 0);
    chk("ac_state", 32'(dut.state), 32'(ENTER_A));
    chk("ac_display", 32'(o_display), 0);
    send(7); send(ADD); send(1); send(EQ);
    alu(7, 1, 0, 0, 0, 0, 0);
    chk("mid_state", 32'(dut.state), 32'(WAIT_RES));
    rst_n = 0;
    #1;
    chk("mid_rst_ready", 32'(o_ready), 1);
    chk("mid_rst_display", 32'(o_display), 0);
    chk("mid_rst_op_a", 32'(o_op_a), 0);
    @(negedge clk);
    rst_n = 1;
    i_res = 99;
    i_res_valid = 1;
    @(negedge clk);
    i_res_valid = 0;
    @(negedge clk);
    chk("post_rst_display", 32'(o_display), 0);
    chk("post_rst_state", 32'(dut.state), 32'(ENTER_A));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
